// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with one-shot and
// auto-reload modes; irq feeds one CP0 hardware interrupt line.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctrl;
  logic [3:0]  ctrl_nxt;
  logic [31:0] preset;
  logic [31:0] preset_nxt;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic        flag;
  logic        flag_nxt;

  logic        en;
  logic        im;
  logic        auto_rl;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        fire;
  logic        unused_addr;

  assign en        = ctrl[0];
  assign im        = ctrl[3];
  assign auto_rl   = (ctrl[2:1] == 2'b01);
  assign wr_ctrl   = we && (addr[3:2] == 2'b00);
  assign wr_preset = we && (addr[3:2] == 2'b01);
  assign fire      = (state == CNT) && en
                     && (count == 32'd0);

  assign unused_addr = ^{addr[31:4], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl   <= ctrl_nxt;
      preset <= preset_nxt;
      count  <= count_nxt;
      flag   <= flag_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ctrl_nxt   = ctrl;
    preset_nxt = preset;
    count_nxt  = count;
    flag_nxt   = flag;

    unique case (state)
      IDLE: begin
        if (en) begin
          count_nxt = preset;
          state_nxt = CNT;
        end
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count != 32'd0) begin
          count_nxt = count - 32'd1;
        end else begin
          state_nxt = INT;
          flag_nxt  = 1'b1;
        end
      end
      INT: begin
        state_nxt = IDLE;
        if (auto_rl) begin
          flag_nxt = 1'b0;
        end else begin
          ctrl_nxt[0] = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A CPU write acknowledges the flag, but a same-edge set wins.
    if (wr_ctrl) begin
      ctrl_nxt = din[3:0];
      if (!fire) begin
        flag_nxt = 1'b0;
      end
    end

    if (wr_preset) begin
      preset_nxt = din;
    end
  end

  always_comb begin
    dout = 32'd0;
    unique case (addr[3:2])
      2'b00:   dout = {28'd0, ctrl};
      2'b01:   dout = preset;
      2'b10:   dout = count;
      default: dout = 32'd0;
    endcase
  end

  assign irq = flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a cycle-level reference
// model compared every cycle plus hand-computed checkpoints.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_PRE  = 32'h4;
  localparam logic [31:0] A_CNT  = 32'h8;
  localparam logic [31:0] A_RSV  = 32'hC;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 waiting, 1 counting down, 2 interrupt cycle
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  int          m_phase;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'b00:   return {28'd0, m_ctrl};
      2'b01:   return m_preset;
      2'b10:   return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit fire;
    fire = 1'b0;
    if (reset) begin
      m_ctrl   = 4'd0;
      m_preset = 32'd0;
      m_count  = 32'd0;
      m_flag   = 1'b0;
      m_phase  = 0;
    end else begin
      if (m_phase == 2) begin
        m_phase = 0;
        if (m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
        else m_ctrl[0] = 1'b0;
      end else if (m_phase == 1) begin
        if (!m_ctrl[0]) m_phase = 0;
        else if (m_count > 0) m_count = m_count - 1;
        else begin
          m_phase = 2;
          fire = 1'b1;
        end
      end else if (m_ctrl[0]) begin
        m_count = m_preset;
        m_phase = 1;
      end
      if (we && addr[3:2] == 2'b00) begin
        m_ctrl = din[3:0];
        if (!fire) m_flag = 1'b0;
      end
      if (fire) m_flag = 1'b1;
      if (we && addr[3:2] == 2'b01) m_preset = din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("irq_model", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
      chk("dout_model", dout, m_read(addr));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rdc(input string name, input logic [31:0] a,
                     input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dout, exp);
  endtask

  task automatic irqc(input string name, input logic exp);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'd0;
    din   = 32'd0;
    step(2);
    reset  = 1'b0;
    cmp_on = 1'b1;

    rdc("rst_ctrl", A_CTRL, 32'd0);
    rdc("rst_pre", A_PRE, 32'd0);
    rdc("rst_cnt", A_CNT, 32'd0);
    irqc("rst_irq", 1'b0);

    // reset mid-count
    wr(A_PRE, 32'd100);
    wr(A_CTRL, 32'h1);
    step(19);
    rdc("mid_cnt", A_CNT, 32'd82);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rdc("mr_ctrl", A_CTRL, 32'd0);
    rdc("mr_cnt", A_CNT, 32'd0);
    irqc("mr_irq", 1'b0);
    step(3);
    rdc("mr_idle", A_CNT, 32'd0);

    // one-shot
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    step(1);
    rdc("os_e1", A_CNT, 32'd5);
    step(5);
    rdc("os_e6", A_CNT, 32'd0);
    irqc("os_e6_irq", 1'b0);
    step(1);
    irqc("os_e7_irq", 1'b1);
    step(1);
    rdc("os_e8_ctrl", A_CTRL, 32'h8);
    irqc("os_e8_irq", 1'b1);
    step(3);
    irqc("os_hold", 1'b1);
    wr(A_CTRL, 32'h8);
    irqc("os_ack", 1'b0);

    // auto-reload
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      step(1);
      irqc($sformatf("ar_e%0d", k), (k == 5 || k == 11 || k == 17));
      if (k == 7) rdc("ar_reload", A_CNT, 32'd3);
    end
    wr(A_CTRL, 32'h0);

    // PRESET=0, masked
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h1);
    step(1);
    rdc("z_e1", A_CNT, 32'd0);
    step(1);
    irqc("z_mask", 1'b0);
    step(1);
    rdc("z_en_clr", A_CTRL, 32'd0);
    wr(A_CTRL, 32'h8);
    irqc("z_ack", 1'b0);

    // disable / re-enable
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    step(4);
    wr(A_CTRL, 32'h0);
    rdc("dis_6", A_CNT, 32'd6);
    step(3);
    rdc("dis_hold", A_CNT, 32'd6);
    wr(A_CTRL, 32'h1);
    step(1);
    rdc("reen", A_CNT, 32'd10);
    wr(A_CTRL, 32'h0);

    // bus: read-only and reserved offsets
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_RSV, 32'hFFFF_FFFF);
    rdc("ro_cnt", A_CNT, 32'd9);
    rdc("rsv_rd", A_RSV, 32'd0);
    rdc("ro_pre", A_PRE, 32'd10);
    rdc("ro_ctrl", A_CTRL, 32'd0);

    // PRESET write while counting
    wr(A_PRE, 32'd4);
    wr(A_CTRL, 32'h1);
    step(1);
    rdc("pw_e1", A_CNT, 32'd4);
    wr(A_PRE, 32'd7);
    rdc("pw_e2", A_CNT, 32'd3);
    rdc("pw_pre", A_PRE, 32'd7);
    step(3);
    rdc("pw_e5", A_CNT, 32'd0);
    step(2);
    rdc("pw_done", A_CTRL, 32'd0);
    wr(A_CTRL, 32'h1);
    step(1);
    rdc("pw_new", A_CNT, 32'd7);
    wr(A_CTRL, 32'h0);

    // CTRL write on INT edge, then on flag-set edge
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h9);
    step(4);
    irqc("sw_int", 1'b1);
    wr(A_CTRL, 32'hD);
    rdc("sw_ctrl", A_CTRL, 32'hD);
    irqc("sw_ack", 1'b0);
    step(1);
    rdc("sw_load", A_CNT, 32'd2);
    step(2);
    rdc("sw_zero", A_CNT, 32'd0);
    wr(A_CTRL, 32'hD);
    irqc("set_wins", 1'b1);
    step(1);
    rdc("m10_ctrl", A_CTRL, 32'hC);
    irqc("m10_irq", 1'b1);
    wr(A_CTRL, 32'h0);
    irqc("final_ack", 1'b0);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
